// File: rtl/wb_uart_tx_if.sv
// Single-beat Wishbone slave port: master drives the request, slave returns data and ack.
interface wb_uart_tx_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [8:0]  adr;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;

   modport master (output cyc, stb, we, adr, sel, dat_w, input  dat_r, ack);
   modport slave  (input  cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone UART transmitter: 4 registers, TX FIFO, 8N1 serializer. Ack one cycle after accept.
// No bus stall; pushes into a full FIFO are acked, dropped and flagged as overflow.
module wb_uart_tx #(
   parameter int               FIFO_DEPTH = 8,
   parameter int               DIV_W      = 16,
   parameter logic [DIV_W-1:0] DIV_RST    = 16'd433
) (
   input  logic         i_clk,
   input  logic         i_rst,
   wb_uart_tx_if.slave  wb,
   output logic         o_uart_tx,
   output logic         o_irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic             r_ack;
   logic [31:0]      r_dat;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [LW-1:0]    r_level;
   logic             r_ovf, r_tx_en, r_irq_en;
   logic [DIV_W-1:0] r_div, r_wdiv, r_cnt;
   state_t           r_state, w_state_nxt;
   logic [7:0]       r_shift;
   logic [2:0]       r_bitcnt;
   logic             r_tx, w_tx_nxt;

   logic             w_acc, w_wr, w_push, w_push_ok, w_ovf_clr, w_pop;
   logic             w_empty, w_full, w_bit_done, w_shift_en, w_start_ok;
   logic [31:0]      w_rdata, w_sel_bits;
   logic [DIV_W-1:0] w_mask;
   logic             w_unused;

   // ack low at the accepting edge is what spaces a held strobe to one ack per two cycles
   assign w_acc      = wb.cyc & wb.stb & ~r_ack;
   assign w_wr       = w_acc & wb.we;
   assign w_push     = w_wr & (wb.adr[1:0] == 2'd0) & wb.sel[0];
   assign w_push_ok  = w_push & ~w_full;
   assign w_ovf_clr  = w_wr & (wb.adr[1:0] == 2'd1) & wb.sel[0] & wb.dat_w[3];
   assign w_empty    = (r_level == '0);
   assign w_full     = (r_level == LW'(FIFO_DEPTH));
   assign w_sel_bits = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
   assign w_mask     = w_sel_bits[DIV_W-1:0];
   assign w_unused   = ^{wb.adr[8:2], wb.dat_w, w_sel_bits};

   assign wb.ack    = r_ack;
   assign wb.dat_r  = r_dat;
   assign o_uart_tx = r_tx;
   assign o_irq     = r_irq_en & w_empty & (r_state == S_IDLE);

   always_comb begin
      w_rdata = '0;
      case (wb.adr[1:0])
         2'd1: begin
            w_rdata[0]       = w_empty;
            w_rdata[1]       = w_full;
            w_rdata[2]       = (r_state != S_IDLE);
            w_rdata[3]       = r_ovf;
            w_rdata[8 +: LW] = r_level;
         end
         2'd2:    w_rdata[DIV_W-1:0] = r_div;
         2'd3:    w_rdata[1:0]       = {r_irq_en, r_tx_en};
         default: w_rdata            = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_acc;
         r_dat <= (w_acc & ~wb.we) ? w_rdata : '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf    <= 1'b0;
         r_div    <= DIV_RST;
         r_tx_en  <= 1'b0;
         r_irq_en <= 1'b0;
      end else begin
         if (w_push & w_full)
            r_ovf <= 1'b1;
         else if (w_ovf_clr)
            r_ovf <= 1'b0;
         if (w_wr && wb.adr[1:0] == 2'd2)
            r_div <= (r_div & ~w_mask) | (wb.dat_w[DIV_W-1:0] & w_mask);
         if (w_wr && wb.adr[1:0] == 2'd3 && wb.sel[0])
            {r_irq_en, r_tx_en} <= wb.dat_w[1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok)
         r_mem[r_wptr] <= wb.dat_w[7:0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push_ok)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign w_bit_done = (r_cnt == r_wdiv);
   assign w_start_ok = r_tx_en & ~w_empty;

   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      w_shift_en  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_start_ok) begin
               w_state_nxt = S_START;
               w_pop       = 1'b1;
               w_tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (w_bit_done) begin
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_done) begin
               w_shift_en = 1'b1;
               if (r_bitcnt == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_tx_nxt = r_shift[1];
               end
            end
         end
         default: begin
            // stop bit ends straight into the next start bit when more data waits
            if (w_bit_done) begin
               if (w_start_ok) begin
                  w_state_nxt = S_START;
                  w_pop       = 1'b1;
                  w_tx_nxt    = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_tx_nxt    = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_tx     <= 1'b1;
         r_cnt    <= '0;
         r_wdiv   <= '0;
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop || w_bit_done || r_state == S_IDLE)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + DIV_W'(1);
         if (w_pop) begin
            r_wdiv  <= r_div;
            r_shift <= r_mem[r_rptr];
         end else if (w_shift_en) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
         if (r_state == S_START)
            r_bitcnt <= '0;
         else if (w_shift_en)
            r_bitcnt <= r_bitcnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register readback, framing, FIFO overflow, irq, mid-frame changes, async reset.
module tb_wb_uart_tx;

   logic clk;
   logic rst;
   logic tx;
   logic irq;
   int   n_pass;
   int   n_total;

   wb_uart_tx_if bus ();

   wb_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16), .DIV_RST(16'd433)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .wb        (bus),
      .o_uart_tx (tx),
      .o_irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Returns one ns after the accepting edge, with ack high and the data captured.
   task automatic wb_acc(input logic [1:0] a, input logic we, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd);
      bit got;
      got = 1'b0;
      while (bus.ack === 1'b1) begin
         @(posedge clk); #1;
      end
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = we;
      bus.adr   = {7'($urandom_range(0, 127)), a};
      bus.sel   = sel;
      bus.dat_w = d;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (bus.ack === 1'b1) got = 1'b1;
      end
      rd        = bus.dat_r;
      bus.cyc   = 1'b0;
      bus.stb   = 1'b0;
      bus.we    = 1'b0;
      bus.dat_w = '0;
      if (!got) begin
         n_total++;
         $display("FAIL bus_timeout: no ack for adr %0d, required ack within 8 cycles", a);
      end
   endtask

   // Samples the line starting now (first cycle of a start bit), one sample per clock.
   task automatic capture_frame(input int cpb, output logic [9:0] bits,
                                output logic stable, output logic irq_hi);
      stable = 1'b1;
      irq_hi = 1'b0;
      bits   = '0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < cpb; c++) begin
            if (c == 0) bits[i] = tx;
            else if (tx !== bits[i]) stable = 1'b0;
            if (irq === 1'b1) irq_hi = 1'b1;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int acks;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_total++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx); else n_pass++;
      n_total++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
      n_total++; if (bus.ack !== 1'b0 || bus.dat_r !== 32'h0)
         $display("FAIL rst_bus: ack %b dat %h want 0/0", bus.ack, bus.dat_r); else n_pass++;
      wb_acc(2'd1, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0000_0001) $display("FAIL rst_status: got %h want 00000001", rd); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.ack !== 1'b0 || bus.dat_r !== 32'h0)
         $display("FAIL ack_width: ack %b dat %h want 0/0 in second cycle", bus.ack, bus.dat_r); else n_pass++;
      wb_acc(2'd2, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'd433) $display("FAIL rst_baud: got %0d want 433", rd); else n_pass++;
      wb_acc(2'd3, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", rd); else n_pass++;
      wb_acc(2'd0, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL txdata_read: got %h want 0", rd); else n_pass++;
      @(posedge clk); #1;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 9'd3;
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.ack === 1'b1) acks++;
      end
      bus.cyc = 1'b0; bus.stb = 1'b0;
      n_total++; if (acks !== 3) $display("FAIL held_stb_acks: got %0d want 3 in 6 cycles", acks); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame();
      logic [31:0] rd;
      logic [9:0]  bits;
      logic        st, ih;
      wb_acc(2'd2, 1'b1, 32'd3, 4'hF, rd);
      wb_acc(2'd3, 1'b1, 32'd1, 4'h1, rd);
      wb_acc(2'd0, 1'b1, 32'hA5, 4'h1, rd);
      n_total++; if (tx !== 1'b1) $display("FAIL single_e0: tx %b want 1 at write edge", tx); else n_pass++;
      @(posedge clk); #1;
      capture_frame(4, bits, st, ih);
      n_total++; if (bits !== 10'b1_1010_0101_0) $display("FAIL single_bits: got %b want 1101001010", bits); else n_pass++;
      n_total++; if (st !== 1'b1) $display("FAIL single_width: stable %b want 1 (4 clocks/bit)", st); else n_pass++;
      n_total++; if (tx !== 1'b1) $display("FAIL single_idle: tx %b want 1", tx); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [9:0]  bits;
      logic        st, ih, stayed;
      wb_acc(2'd3, 1'b1, 32'd0, 4'h1, rd);
      for (int b = 0; b < 9; b++) wb_acc(2'd0, 1'b1, 32'(b), 4'h1, rd);
      wb_acc(2'd1, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0000_080A) $display("FAIL ovf_status: got %h want 0000080A", rd); else n_pass++;
      wb_acc(2'd1, 1'b1, 32'h8, 4'h1, rd);
      wb_acc(2'd1, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0000_0802) $display("FAIL ovf_clear: got %h want 00000802", rd); else n_pass++;
      wb_acc(2'd3, 1'b1, 32'd1, 4'h1, rd);
      @(posedge clk); #1;
      for (int f = 0; f < 8; f++) begin
         capture_frame(4, bits, st, ih);
         n_total++; if (bits !== {1'b1, 8'(f), 1'b0} || st !== 1'b1)
            $display("FAIL b2b_frame%0d: got %b stable %b want %b stable 1", f, bits, st, {1'b1, 8'(f), 1'b0});
         else n_pass++;
      end
      stayed = 1'b1;
      repeat (60) begin
         if (tx !== 1'b1) stayed = 1'b0;
         @(posedge clk); #1;
      end
      n_total++; if (stayed !== 1'b1) $display("FAIL dropped_byte: line left idle, want no ninth frame"); else n_pass++;
      wb_acc(2'd1, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0000_0001) $display("FAIL b2b_drained: got %h want 00000001", rd); else n_pass++;
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      logic [9:0]  bits;
      logic        st, ih;
      wb_acc(2'd3, 1'b1, 32'd3, 4'h1, rd);
      n_total++; if (irq !== 1'b1) $display("FAIL irq_idle: got %b want 1", irq); else n_pass++;
      wb_acc(2'd0, 1'b1, 32'h3C, 4'h1, rd);
      n_total++; if (irq !== 1'b0) $display("FAIL irq_push: got %b want 0 at push edge", irq); else n_pass++;
      @(posedge clk); #1;
      capture_frame(4, bits, st, ih);
      n_total++; if (bits !== {1'b1, 8'h3C, 1'b0} || ih !== 1'b0)
         $display("FAIL irq_frame: bits %b irq_during %b want %b / 0", bits, ih, {1'b1, 8'h3C, 1'b0}); else n_pass++;
      n_total++; if (irq !== 1'b1) $display("FAIL irq_done: got %b want 1 after STOP", irq); else n_pass++;
   endtask

   task automatic test_mid_frame();
      logic [31:0] rd;
      logic [9:0]  b1, b2;
      logic        s1, s2, ih, stayed;
      wb_acc(2'd3, 1'b1, 32'd0, 4'h1, rd);
      wb_acc(2'd0, 1'b1, 32'h11, 4'h1, rd);
      wb_acc(2'd0, 1'b1, 32'h22, 4'h1, rd);
      wb_acc(2'd3, 1'b1, 32'd1, 4'h1, rd);
      @(posedge clk); #1;
      fork
         capture_frame(4, b1, s1, ih);
         begin
            repeat (5) begin @(posedge clk); #1; end
            wb_acc(2'd2, 1'b1, 32'd7, 4'hF, rd);
         end
      join
      capture_frame(8, b2, s2, ih);
      n_total++; if (b1 !== {1'b1, 8'h11, 1'b0} || s1 !== 1'b1)
         $display("FAIL baud_f1: got %b stable %b want %b stable 1", b1, s1, {1'b1, 8'h11, 1'b0}); else n_pass++;
      n_total++; if (b2 !== {1'b1, 8'h22, 1'b0} || s2 !== 1'b1)
         $display("FAIL baud_f2: got %b stable %b want %b stable 1 (8 clocks/bit)", b2, s2, {1'b1, 8'h22, 1'b0}); else n_pass++;

      wb_acc(2'd2, 1'b1, 32'd3, 4'hF, rd);
      wb_acc(2'd3, 1'b1, 32'd0, 4'h1, rd);
      wb_acc(2'd0, 1'b1, 32'h5A, 4'h1, rd);
      wb_acc(2'd0, 1'b1, 32'h6B, 4'h1, rd);
      wb_acc(2'd3, 1'b1, 32'd1, 4'h1, rd);
      @(posedge clk); #1;
      fork
         capture_frame(4, b1, s1, ih);
         begin
            repeat (5) begin @(posedge clk); #1; end
            wb_acc(2'd3, 1'b1, 32'd0, 4'h1, rd);
         end
      join
      n_total++; if (b1 !== {1'b1, 8'h5A, 1'b0} || s1 !== 1'b1)
         $display("FAIL txen_f1: got %b stable %b want %b stable 1", b1, s1, {1'b1, 8'h5A, 1'b0}); else n_pass++;
      stayed = 1'b1;
      repeat (30) begin
         if (tx !== 1'b1) stayed = 1'b0;
         @(posedge clk); #1;
      end
      n_total++; if (stayed !== 1'b1) $display("FAIL txen_hold: line left idle, want frame 2 held"); else n_pass++;
      wb_acc(2'd1, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0000_0100) $display("FAIL txen_level: got %h want 00000100", rd); else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      wb_acc(2'd3, 1'b1, 32'd1, 4'h1, rd);
      repeat (14) begin @(posedge clk); #1; end
      n_total++; if (tx !== 1'b0) $display("FAIL arst_pre: tx %b want 0 in data bit 2 of 0x6B", tx); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++; if (tx !== 1'b1) $display("FAIL arst_tx: tx %b want 1 without clock edge", tx); else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wb_acc(2'd1, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0000_0001) $display("FAIL arst_status: got %h want 00000001", rd); else n_pass++;
      wb_acc(2'd3, 1'b0, 32'h0, 4'hF, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL arst_ctrl: got %h want 0", rd); else n_pass++;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      bus.cyc   = 1'b0;
      bus.stb   = 1'b0;
      bus.we    = 1'b0;
      bus.adr   = '0;
      bus.sel   = '0;
      bus.dat_w = '0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_irq();
      test_mid_frame();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
